xalu_sched: RTL and testbench

XALU_SCHED -- requirements
Module: xalu_sched

---
 rtl/xalu_sched.sv | 137 +++++++++++++
 tb/tb_xalu_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/xalu_sched.sv
// xalu_sched -- issue scheduler in front of the HI/LO multiply/divide unit.
//
// Accepts mult/multu/div/divu/mthi/mtlo requests from the pipeline, holds
// at most one of them in a pending buffer while the unit is occupied, and
// issues them to the unit as a registered one-cycle Start pulse. mfhi/mflo
// are granted only when the unit is idle with nothing queued. A watchdog
// aborts a unit that stays busy too long and raises a sticky Error.
//
// Ports
//   Clock, Reset       rising-edge clock, synchronous active-high reset
//   Req, ReqOp         request strobe and op (0-5 unit ops, 6 mfhi, 7 mflo)
//   ReqA, ReqB         operands (rs, rt)
//   Flush              drop the buffered request, ignore Req this cycle
//   XBusy              busy flag from the multiply/divide unit
//   Start, XALUOp,     registered issue to the unit
//   XA, XB
//   Stall              request not accepted this cycle (combinational)
//   ReadValid, ReadSel mfhi/mflo granted; 0 = HI, 1 = LO (combinational)
//   Error              sticky watchdog error
//   DoneCnt            completed unit operations, wraps at 16 bits
module xalu_sched (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req,
    input  logic [2:0]  ReqOp,
    input  logic [31:0] ReqA,
    input  logic [31:0] ReqB,
    input  logic        Flush,
    input  logic        XBusy,
    output logic        Start,
    output logic [2:0]  XALUOp,
    output logic [31:0] XA,
    output logic [31:0] XB,
    output logic        Stall,
    output logic        ReadValid,
    output logic        ReadSel,
    output logic        Error,
    output logic [15:0] DoneCnt
);

    typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

    state_t      state;
    logic        pend_v;
    logic [2:0]  pend_op;
    logic [31:0] pend_a;
    logic [31:0] pend_b;
    logic [3:0]  wd;

    logic is_read, req_live, acc_xop, acc_read;
    logic busy_done, wd_trip, to_idle, issue_pend, issue_new;

    always_comb begin
        is_read  = ReqOp[2] & ReqOp[1];
        req_live = Req & ~Flush & ~Reset;
        acc_xop  = req_live & ~is_read & ~pend_v;
        // With the unit idle and nothing pending, a read op can never coincide
        // with an issue on the same edge, so no extra issue term is needed.
        acc_read = req_live & is_read & (state == IDLE) & ~pend_v;

        Stall     = req_live & ~(acc_xop | acc_read);
        ReadValid = acc_read;
        ReadSel   = ReqOp[0];

        // wd == 0 marks the first BUSY cycle; XBusy is ignored there because
        // the unit may not have raised it yet.
        busy_done = (state == BUSY) & (wd != 4'd0) & ~XBusy;
        wd_trip   = (state == BUSY) & ~busy_done & (wd == 4'd14);
        // mthi/mtlo (op bit 2 set) take no unit time
        to_idle   = ((state == START) & XALUOp[2]) | busy_done | wd_trip;

        // A pending entry goes out on the edge the state returns to IDLE, or
        // from IDLE if it was buffered on that same returning edge.
        issue_pend = pend_v & ~Flush & ((state == IDLE) | to_idle);
        issue_new  = acc_xop & (state == IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            pend_v  <= 1'b0;
            pend_op <= 3'd0;
            pend_a  <= 32'd0;
            pend_b  <= 32'd0;
            wd      <= 4'd0;
            Start   <= 1'b0;
            XALUOp  <= 3'd0;
            XA      <= 32'd0;
            XB      <= 32'd0;
            Error   <= 1'b0;
            DoneCnt <= 16'd0;
        end else begin
            Start <= issue_pend | issue_new;

            if (issue_pend) begin
                XALUOp <= pend_op;
                XA     <= pend_a;
                XB     <= pend_b;
            end else if (issue_new) begin
                XALUOp <= ReqOp;
                XA     <= ReqA;
                XB     <= ReqB;
            end

            if (issue_pend | issue_new) begin
                state <= START;
            end else begin
                case (state)
                    START:   state <= XALUOp[2] ? IDLE : BUSY;
                    BUSY:    if (busy_done | wd_trip) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end

            if ((state == BUSY) & ~busy_done & ~wd_trip)
                wd <= wd + 4'd1;
            else
                wd <= 4'd0;

            if (wd_trip)
                Error <= 1'b1;

            if (busy_done)
                DoneCnt <= DoneCnt + 16'd1;

            if (Flush | issue_pend) begin
                pend_v <= 1'b0;
            end else if (acc_xop & (state != IDLE)) begin
                pend_v  <= 1'b1;
                pend_op <= ReqOp;
                pend_a  <= ReqA;
                pend_b  <= ReqB;
            end
        end
    end

endmodule

// File: tb/tb_xalu_sched.sv
module tb_xalu_sched;

    logic        Clock;
    logic        Reset;
    logic        Req;
    logic [2:0]  ReqOp;
    logic [31:0] ReqA;
    logic [31:0] ReqB;
    logic        Flush;
    logic        XBusy;
    logic        Start;
    logic [2:0]  XALUOp;
    logic [31:0] XA;
    logic [31:0] XB;
    logic        Stall;
    logic        ReadValid;
    logic        ReadSel;
    logic        Error;
    logic [15:0] DoneCnt;

    xalu_sched dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .ReqOp(ReqOp),
        .ReqA(ReqA), .ReqB(ReqB), .Flush(Flush), .XBusy(XBusy),
        .Start(Start), .XALUOp(XALUOp), .XA(XA), .XB(XB),
        .Stall(Stall), .ReadValid(ReadValid), .ReadSel(ReadSel),
        .Error(Error), .DoneCnt(DoneCnt)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        bit          stall, rv, rsel, start, err;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [15:0] done;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b;
    } req_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Reference model: the unit is either emitting its start pulse, counting
    // busy cycles (age >= 0), or free; waiting requests live in a queue.
    bit          m_pulse;
    logic [2:0]  m_op;
    logic [31:0] m_a, m_b;
    int          m_age;
    req_t        m_pend[$];
    logic [15:0] m_done;
    bit          m_err;

    task automatic m_reset();
        m_pulse = 0; m_op = 0; m_a = 0; m_b = 0; m_age = -1;
        m_pend.delete(); m_done = 0; m_err = 0;
    endtask

    task automatic m_issue(input logic [2:0] op, input logic [31:0] a, b);
        m_pulse = 1; m_op = op; m_a = a; m_b = b;
    endtask

    task automatic cyc(input bit rst, req, input logic [2:0] op,
                       input logic [31:0] a, b, input bit fl, xb);
        exp_t e;
        bit   free, leave;
        req_t r;
        @(posedge Clock); #1;
        Reset = rst; Req = req; ReqOp = op; ReqA = a; ReqB = b;
        Flush = fl; XBusy = xb;

        free = !m_pulse && m_age < 0;
        e.stall = 0; e.rv = 0; e.rsel = 0;
        if (!rst && req && !fl) begin
            if (op < 6) e.stall = (m_pend.size() != 0);
            else if (free && m_pend.size() == 0) begin e.rv = 1; e.rsel = op[0]; end
            else e.stall = 1;
        end
        e.start = m_pulse; e.op = m_op; e.a = m_a; e.b = m_b;
        e.done = m_done; e.err = m_err;
        exp_q.push_back(e);

        if (rst) begin
            m_reset();
        end else begin
            leave = 0;
            if (m_pulse) begin
                m_pulse = 0;
                if (m_op < 4) m_age = 0; else leave = 1;
            end else if (m_age >= 0) begin
                if (m_age >= 1 && !xb) begin
                    m_done = m_done + 16'd1; m_age = -1; leave = 1;
                end else begin
                    m_age++;
                    if (m_age == 15) begin m_err = 1; m_age = -1; leave = 1; end
                end
            end
            if (fl) begin
                m_pend.delete();
            end else if (m_pend.size() != 0 && (free || leave)) begin
                r = m_pend.pop_front();
                m_issue(r.op, r.a, r.b);
            end else if (req && op < 6 && m_pend.size() == 0) begin
                if (free) m_issue(op, a, b);
                else begin r.op = op; r.a = a; r.b = b; m_pend.push_back(r); end
            end
        end
    endtask

    task automatic idle(input int n, input bit xb);
        for (int i = 0; i < n; i++) cyc(0, 0, 3'd0, 32'd0, 32'd0, 0, xb);
    endtask

    task automatic chk(input string name, input logic [31:0] act, exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents one set of outputs, compared
    // against the oldest expected record.
    always @(negedge Clock) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stall", 32'(Stall), 32'(e.stall));
            chk("readvalid", 32'(ReadValid), 32'(e.rv));
            if (e.rv) chk("readsel", 32'(ReadSel), 32'(e.rsel));
            chk("start", 32'(Start), 32'(e.start));
            chk("xaluop", 32'(XALUOp), 32'(e.op));
            chk("xa", XA, e.a);
            chk("xb", XB, e.b);
            chk("error", 32'(Error), 32'(e.err));
            chk("donecnt", 32'(DoneCnt), 32'(e.done));
        end
    end

    initial begin
        Reset = 1; Req = 0; ReqOp = 0; ReqA = 0; ReqB = 0; Flush = 0; XBusy = 0;
        m_reset();
        repeat (2) @(posedge Clock);

        // mult -7 * 13, unit busy for five cycles
        cyc(0, 1, 3'd0, 32'(-7), 32'd13, 0, 0);
        cyc(0, 0, 3'd0, 32'd0, 32'd0, 0, 0);
        idle(5, 1);
        idle(3, 0);

        // div, divu buffered, third op stalls; mflo stalls while busy
        cyc(0, 1, 3'd2, 32'd8, 32'd3, 0, 0);
        cyc(0, 1, 3'd3, 32'(-8), 32'(-198), 0, 0);
        cyc(0, 1, 3'd1, 32'd5, 32'd6, 0, 1);
        cyc(0, 1, 3'd7, 32'd0, 32'd0, 0, 1);
        idle(3, 1);
        idle(1, 0);
        idle(3, 1);
        for (int i = 0; i < 4; i++) cyc(0, 1, 3'd7, 32'd0, 32'd0, 0, 0);

        // mthi then mtlo back to back
        cyc(0, 1, 3'd4, 32'd100, 32'd0, 0, 0);
        cyc(0, 1, 3'd5, 32'd300, 32'd0, 0, 0);
        idle(4, 0);

        // flush while pending is full
        cyc(0, 1, 3'd0, 32'd2, 32'd3, 0, 0);
        cyc(0, 1, 3'd1, 32'd4, 32'd5, 0, 0);
        cyc(0, 1, 3'd2, 32'd9, 32'd9, 1, 1);
        idle(3, 1);
        idle(4, 0);

        // watchdog, then reset with a request held high
        cyc(0, 1, 3'd0, 32'd1, 32'd1, 0, 1);
        idle(20, 1);
        cyc(0, 1, 3'd6, 32'd0, 32'd0, 0, 1);
        cyc(1, 1, 3'd0, 32'd7, 32'd7, 0, 0);
        idle(2, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(199, 0) == 0), ($urandom_range(1, 0) == 1),
                3'($urandom_range(7, 0)), $urandom, $urandom,
                ($urandom_range(15, 0) == 0), ($urandom_range(9, 0) < 7));
        end
        idle(2, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge Clock);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end
        @(negedge Clock);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
